// File: rtl/switch_bounce_gen_if.sv
// Request/level handshake and switch contact bundle
// for the mechanical switch emulator.
interface switch_bounce_gen_if;
    logic req_i;
    logic level_i;
    logic ready_o;
    logic busy_o;
    logic done_o;
    logic sw_o;

    modport master (
        output req_i,
        output level_i,
        input  ready_o,
        input  busy_o,
        input  done_o,
        input  sw_o
    );

    modport slave (
        input  req_i,
        input  level_i,
        output ready_o,
        output busy_o,
        output done_o,
        output sw_o
    );
endinterface

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: each accepted level change becomes
// an LFSR-timed bounce burst of fixed length, then a stable settle.
module switch_bounce_gen #(
    parameter int unsigned ClkFreq      = 100_000_000,
    parameter int unsigned BounceTimeUs = 1000,
    parameter int unsigned GlitchBits   = 6,
    parameter logic [15:0] LfsrSeed     = 16'hACE1,
    parameter logic        InitLevel    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    switch_bounce_gen_if.slave bus
);

    localparam int unsigned BounceCycles =
        ClkFreq / 1_000_000 * BounceTimeUs;
    localparam int unsigned CntW =
        (BounceCycles > 2) ? $clog2(BounceCycles) : 1;
    localparam int unsigned SegW = GlitchBits + 1;
    localparam logic [15:0] Seed =
        (LfsrSeed == 16'h0) ? 16'hACE1 : LfsrSeed;
    localparam logic [CntW-1:0] CntLoad =
        CntW'(BounceCycles - 1);
    localparam logic [SegW-1:0] SegOne = SegW'(1);

    if (BounceCycles < 2) begin : g_bad_bounce
        $error("BounceCycles must be at least 2");
    end
    if (GlitchBits < 1 || GlitchBits > 15) begin : g_bad_glitch
        $error("GlitchBits must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            sw_q, sw_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tgt_q, tgt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SegW-1:0] seg_q, seg_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [SegW-1:0] seg_len;

    // Galois right-shift, taps 0xB400; free-running in every state
    assign lfsr_d = {1'b0, lfsr_q[15:1]}
                  ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign seg_len = {1'b0, lfsr_q[GlitchBits-1:0]} + SegOne;

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    tgt_d   = bus.level_i;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (bus.level_i == sw_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BOUNCE;
                        sw_d    = bus.level_i;
                        cnt_d   = CntLoad;
                        seg_d   = seg_len;
                    end
                end
            end
            BOUNCE: begin
                // burst end takes priority over a segment toggle
                if (cnt_q == '0) begin
                    sw_d    = tgt_q;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (seg_q == SegOne) begin
                        sw_d  = ~sw_q;
                        seg_d = seg_len;
                    end else begin
                        seg_d = seg_q - SegOne;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sw_q    <= InitLevel;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tgt_q   <= InitLevel;
            cnt_q   <= '0;
            seg_q   <= '0;
            lfsr_q  <= Seed;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign bus.sw_o    = sw_q;
    assign bus.ready_o = ready_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Self-checking bench for switch_bounce_gen: vector table,
// directed corner cases and randomized requests vs a schedule model.
module tb_switch_bounce_gen;

    localparam int unsigned CF = 10_000_000;
    localparam int unsigned BT = 10;
    localparam int unsigned GB = 3;
    localparam int BC = 100;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] MASK = 16'((1 << GB) - 1);
    localparam int DB_N = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    switch_bounce_gen_if bus ();

    switch_bounce_gen #(
        .ClkFreq      (CF),
        .BounceTimeUs (BT),
        .GlitchBits   (GB),
        .LfsrSeed     (SEED),
        .InitLevel    (1'b0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic m_sw;
    logic exp_sw [0:BC+1];
    int exp_tr;
    int cap = 0;
    logic w1 [$];
    logic w2 [$];

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // LFSR as seen by the spec: seed in reset, one step per cycle
    logic [15:0] m_lfsr;
    always @(posedge clk)
        m_lfsr <= rst_n ? lstep(m_lfsr) : SEED;

    // simple debouncer fed by the emulated contact
    logic db_level;
    logic db_tick;
    int db_cnt;
    int tick_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_tick  <= 1'b0;
            db_cnt   <= 0;
        end else if (bus.sw_o != db_level) begin
            if (db_cnt == DB_N - 1) begin
                db_level <= bus.sw_o;
                db_tick  <= 1'b1;
                db_cnt   <= 0;
            end else begin
                db_tick <= 1'b0;
                db_cnt  <= db_cnt + 1;
            end
        end else begin
            db_tick <= 1'b0;
            db_cnt  <= 0;
        end
    end
    always @(posedge clk)
        if (db_tick === 1'b1) tick_cnt <= tick_cnt + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (cap == 1) w1.push_back(bus.sw_o);
        else if (cap == 2) w2.push_back(bus.sw_o);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ready"}, 32'(bus.ready_o), 1);
        chk({name, "_busy"}, 32'(bus.busy_o), 0);
        chk({name, "_done"}, 32'(bus.done_o), 0);
        chk({name, "_sw"}, 32'(bus.sw_o), 32'(m_sw));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk_idle("idle");
        end
    endtask

    task automatic do_reset(input int n);
        bus.req_i   = 1'b1;
        bus.level_i = 1'b1;
        rst_n = 1'b0;
        m_sw = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk_idle("rst");
        end
        rst_n = 1'b1;
        bus.req_i = 1'b0;
    endtask

    // toggle schedule derived from the segment-length rule
    task automatic build_sched(input logic [15:0] l0,
                               input logic tgt);
        logic [15:0] l;
        logic v;
        int tt;
        int s;
        l = l0;
        v = tgt;
        s = 1 + int'(l & MASK);
        for (int j = 0; j < s; j++) l = lstep(l);
        tt = s;
        exp_tr = 1;
        exp_sw[0] = ~tgt;
        for (int k = 1; k <= BC; k++) begin
            if (k == tt + 1) begin
                v = ~v;
                exp_tr++;
                s = 1 + int'(l & MASK);
                for (int j = 0; j < s; j++) l = lstep(l);
                tt += s;
            end
            exp_sw[k] = v;
        end
        if (v != tgt) exp_tr++;
        exp_sw[BC+1] = tgt;
    endtask

    task automatic run_req(input logic lvl,
                           input int ign_k,
                           input logic ign_lvl);
        logic [15:0] l0;
        int tr;
        logic prev;
        chk("pre_ready", 32'(bus.ready_o), 1);
        l0 = m_lfsr;
        bus.req_i   = 1'b1;
        bus.level_i = lvl;
        if (lvl == m_sw) begin
            step();
            bus.req_i = 1'b0;
            chk("same_done", 32'(bus.done_o), 1);
            chk("same_busy", 32'(bus.busy_o), 1);
            chk("same_ready", 32'(bus.ready_o), 0);
            chk("same_sw", 32'(bus.sw_o), 32'(m_sw));
            step();
            chk_idle("same_after");
        end else begin
            build_sched(l0, lvl);
            tr = 0;
            prev = m_sw;
            for (int k = 1; k <= BC + 1; k++) begin
                step();
                bus.req_i   = (k == ign_k);
                bus.level_i = (k == ign_k) ? ign_lvl : lvl;
                chk($sformatf("burst_sw_%0d", k),
                    32'(bus.sw_o), 32'(exp_sw[k]));
                chk($sformatf("burst_done_%0d", k),
                    32'(bus.done_o), 32'(k == BC + 1));
                if (k == 1 || k == BC + 1) begin
                    chk("burst_busy", 32'(bus.busy_o), 1);
                    chk("burst_ready", 32'(bus.ready_o), 0);
                end
                if (bus.sw_o !== prev) tr++;
                prev = bus.sw_o;
            end
            bus.req_i = 1'b0;
            m_sw = lvl;
            step();
            chk_idle("burst_end");
            chk("trans_count", 32'(tr), 32'(exp_tr));
            chk("trans_odd", 32'(tr % 2), 1);
            chk("trans_min3", 32'(tr >= 3), 1);
        end
    endtask

    task automatic det_run(input int sel);
        int t0;
        cap = sel;
        do_reset(3);
        t0 = tick_cnt;
        run_req(1'b1, -1, 1'b0);
        idle(30);
        chk("db_tick_press", 32'(tick_cnt - t0), 1);
        chk("db_level_press", 32'(db_level), 1);
        run_req(1'b0, -1, 1'b0);
        idle(30);
        chk("db_tick_release", 32'(tick_cnt - t0), 2);
        chk("db_level_release", 32'(db_level), 0);
        cap = 0;
    endtask

    typedef struct {
        logic req;
        logic lvl;
        logic ready;
        logic busy;
        logic done;
        logic sw;
    } vec_t;

    vec_t tv [6];

    initial begin
        int mism;
        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.req_i   = 1'b0;
        bus.level_i = 1'b0;
        rst_n = 1'b0;
        do_reset(5);

        foreach (tv[i]) begin
            bus.req_i   = tv[i].req;
            bus.level_i = tv[i].lvl;
            step();
            chk($sformatf("tv%0d_ready", i),
                32'(bus.ready_o), 32'(tv[i].ready));
            chk($sformatf("tv%0d_busy", i),
                32'(bus.busy_o), 32'(tv[i].busy));
            chk($sformatf("tv%0d_done", i),
                32'(bus.done_o), 32'(tv[i].done));
            chk($sformatf("tv%0d_sw", i),
                32'(bus.sw_o), 32'(tv[i].sw));
        end
        bus.req_i = 1'b0;

        run_req(1'b1, -1, 1'b0);
        idle(2);
        run_req(1'b1, -1, 1'b0);
        run_req(1'b0, -1, 1'b0);
        run_req(1'b1, 40, 1'b0);
        chk("ignore_sw", 32'(bus.sw_o), 1);
        run_req(1'b0, -1, 1'b0);

        bus.req_i   = 1'b1;
        bus.level_i = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            bus.req_i = 1'b0;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_sw = 1'b0;
        chk_idle("midrst");
        idle(110);

        det_run(1);
        det_run(2);
        chk("det_len", 32'(w1.size()), 32'(w2.size()));
        mism = 0;
        for (int i = 0; i < w1.size() && i < w2.size(); i++)
            if (w1[i] !== w2[i]) mism++;
        chk("det_wave", 32'(mism), 0);
        chk("det_nonempty", 32'(w1.size() > 200), 1);

        for (int n = 0; n < 30; n++) begin
            logic lvl;
            int ign;
            idle(int'($urandom_range(0, 3)));
            lvl = 1'($urandom);
            ign = ($urandom % 2 == 0) ?
                  int'($urandom_range(2, BC)) : -1;
            run_req(lvl, ign, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

Synthesizable mechanical-switch emulator driving the debouncer's `sw_i` input from a clean level command. Each accepted level change becomes a pseudo-random bounce burst of fixed total duration, then a stable settle at the commanded level. It is used in directed benches and in on-board self-test, where it replaces a physical switch so debouncer behaviour is repeatable.

## Interface
- `ClkFreq`, default 100_000_000: clock frequency, Hz.
- `BounceTimeUs`, default 1000: bounce burst duration, µs.
- `GlitchBits`, default 6: width of the random segment length; segment length range 1..2^GlitchBits cycles.
- `LfsrSeed`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.
- `InitLevel`, default 1'b0: `sw_o` level out of reset.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  synchronous reset, active-low.
- `req_i`  in  1  request valid.
- `level_i`  in  1  commanded switch level; sampled only on accept.
- `ready_o`  out  1  block idle, request accepted this cycle if `req_i`=1.
- `busy_o`  out  1  bounce or done phase in progress.
- `done_o`  out  1  one-cycle pulse: `sw_o` has reached the target and is stable.
- `sw_o`  out  1  emulated switch contact, to debouncer `sw_i`.

## Operation
- BounceCycles = ClkFreq/1_000_000 * BounceTimeUs, integer arithmetic.
- Elaboration error if BounceCycles < 2 or GlitchBits is outside 1..15.
- LFSR: 16-bit Galois, taps 16'hB400, right-shift.
  - Advances every cycle out of reset, regardless of state.
  - Segment length = 1 + lfsr[GlitchBits-1:0], taken from the LFSR value registered in the load cycle.
- FSM states: IDLE, BOUNCE, DONE. All outputs are registered.
- IDLE:
  - `ready_o`=1, `busy_o`=0.
  - Accept when `req_i`=1; latch target = `level_i`.
  - If target == `sw_o`, go to DONE; `sw_o` is unchanged.
  - Otherwise go to BOUNCE: set `sw_o` to target (first edge), load the bounce counter with BounceCycles-1, and load the segment timer.
- BOUNCE:
  - Bounce counter decrements every cycle.
  - Segment timer decrements; at 1 it toggles `sw_o` and reloads a new segment length.
  - When the bounce counter reaches 0, force `sw_o` to target and go to DONE. If a segment expires in the same cycle, bounce end wins: no toggle.
- DONE: `done_o`=1 for exactly this cycle, then go to IDLE.
- `req_i` outside IDLE is ignored and not queued.
- Reset asserted in any state: abort immediately, return to IDLE with reset values on the next edge.
- Reset values: `sw_o`=InitLevel, `ready_o`=1, `busy_o`=0, `done_o`=0, LFSR=LfsrSeed. Requests are ignored while `rst_ni`=0.

## Timing
- Accept edge t (req_i & ready_o sampled high). At t+1: `ready_o`=0, `busy_o`=1.
- Level change:
  - t+1: `sw_o`=target.
  - t+1 .. t+BounceCycles: bounce window; `sw_o` may toggle on any cycle, segment ≥ 1 cycle.
  - t+BounceCycles+1: `sw_o`=target, `done_o`=1.
  - t+BounceCycles+2: `ready_o`=1, `busy_o`=0; `sw_o` holds target until the next accepted change or reset.
- Same-level request: t+1 `done_o`=1, `busy_o`=1, `sw_o` constant; t+2 `ready_o`=1.
- Back-to-back: a request held high across `done_o` is accepted at the first edge where `ready_o`=1.
- Total `sw_o` transitions per level-change request are always odd.

## Test plan
All scenarios except 1 use ClkFreq=10_000_000, BounceTimeUs=10 (BounceCycles=100), GlitchBits=3.
1. Reset: `rst_ni`=0 for 5 cycles with `req_i`=1, `level_i`=1 -> `sw_o`=0, `ready_o`=1, `busy_o`=0, `done_o`=0 throughout; no accept.
2. Press: `req_i`=1, `level_i`=1 for one cycle at t ->
   - `sw_o`=1 at t+1;
   - odd transition count (≥3 expected at GlitchBits=3);
   - `done_o` high only at t+101, with `sw_o`=1 stable from t+101;
   - `ready_o`=1 at t+102.
3. Same level: with `sw_o`=1, request `level_i`=1 -> `done_o` at t+1, zero transitions on `sw_o`, `ready_o` at t+2.
4. Busy ignore: accept `level_i`=1, then at t+40 pulse `req_i` with `level_i`=0 -> no effect; `done_o` at t+101, `sw_o` ends 1, no second burst.
5. Mid-bounce reset: accept `level_i`=1, assert `rst_ni`=0 at t+50 for 1 cycle -> `sw_o`=0, `ready_o`=1, `busy_o`=0 on the next edge; no `done_o`.
6. Integration and determinism: drive the debouncer `sw_i` from `sw_o`; run press then release, twice from reset with seed 16'hACE1 ->
   - identical `sw_o` waveforms on both runs;
   - exactly one debouncer `db_tick_o` per request;
   - `db_level_o` follows the target.
